// File: rtl/vga_scanout.sv
// vga_scanout: pixel scan-out stage between the VGA timing generator and the RGB pins.
// Stage A issues the VRAM port-B byte address, a side pipeline carries the pixel
// bit index, vidon and syncs across the VRAM read latency, and stage B maps the
// pixel bit through the fg/bg palette to RGB332.
// Optional feature macro: SCANOUT_PALETTE_EN (writable palette registers).
module vga_scanout #(
  parameter int         RD_LAT   = 1,
  parameter logic [7:0] FG_RESET = 8'hFF,
  parameter logic [7:0] BG_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [9:0]  x_in,
  input  logic [9:0]  y_in,
  input  logic        vidon_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [15:0] vram_addrb,
  input  logic [7:0]  vram_doutb,
  input  logic        cfg_we,
  input  logic        cfg_sel,
  input  logic [7:0]  cfg_data,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_tick
);

  localparam int LAST = RD_LAT - 1;

  typedef struct packed {
    logic [2:0] xbit;
    logic       vidon;
    logic       hs;
    logic       vs;
  } side_t;

  localparam side_t SIDE_RST = '{xbit: 3'd0, vidon: 1'b0, hs: 1'b1, vs: 1'b1};

  side_t       side_a;
  side_t       side_d [RD_LAT];
  logic [15:0] y_ext;
  logic [15:0] addr_next;
  logic [7:0]  fg;
  logic [7:0]  bg;
  logic        pix;
  logic        vsync_prev;

  // Byte address: y*80 as (y<<6)+(y<<4) plus the byte column, wrapped to 16 bits.
  always_comb begin
    y_ext     = {6'd0, y_in};
    addr_next = (y_ext << 6) + (y_ext << 4) + {9'd0, x_in[9:3]};
  end

  // Stage A: register the address and the first side-pipeline stage.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vram_addrb <= 16'd0;
      side_a     <= SIDE_RST;
    end else begin
      vram_addrb <= vidon_in ? addr_next : 16'd0;
      side_a     <= '{xbit: x_in[2:0], vidon: vidon_in, hs: hsync_in, vs: vsync_in};
    end
  end

  // Delay line: RD_LAT stages so side info lands in the same cycle as vram_doutb.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < RD_LAT; i++) side_d[i] <= SIDE_RST;
    end else begin
      side_d[0] <= side_a;
      for (int i = 1; i < RD_LAT; i++) side_d[i] <= side_d[i-1];
    end
  end

  // Pixel bit select: bit 0 is the leftmost pixel of the byte.
  always_comb begin
    pix = vram_doutb[side_d[LAST].xbit];
  end

`ifdef SCANOUT_PALETTE_EN
  // Palette registers; a write is visible to stage B from the next edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fg <= FG_RESET;
      bg <= BG_RESET;
    end else if (cfg_we) begin
      if (cfg_sel) bg <= cfg_data;
      else         fg <= cfg_data;
    end
  end
`else
  // Fixed palette; cfg_* are kept on the port list but have no effect.
  logic unused_cfg;
  assign fg         = FG_RESET;
  assign bg         = BG_RESET;
  assign unused_cfg = ^{cfg_we, cfg_sel, cfg_data};
`endif

  // Stage B: colour mapping, aligned syncs and the vsync falling-edge tick.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      {red, green, blue} <= 8'h00;
      hsync              <= 1'b1;
      vsync              <= 1'b1;
      vsync_prev         <= 1'b1;
      frame_tick         <= 1'b0;
    end else begin
      {red, green, blue} <= side_d[LAST].vidon ? (pix ? fg : bg) : 8'h00;
      hsync              <= side_d[LAST].hs;
      vsync              <= side_d[LAST].vs;
      vsync_prev         <= vsync;
      frame_tick         <= vsync_prev & ~vsync;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: two instances (RD_LAT=1 and RD_LAT=3) share one stimulus
// stream; a spec-level model predicts every output each cycle, and directed
// literal checks pin the model.
module tb_vga_scanout;

  localparam int         MAXE   = 2048;
  localparam logic [7:0] FG_RST = 8'hFF;
  localparam logic [7:0] BG_RST = 8'h00;
  localparam int         L1     = 3;
  localparam int         L3     = 5;
`ifdef SCANOUT_PALETTE_EN
  localparam logic [7:0] EXP_FG2 = 8'hE0;
  localparam logic [7:0] EXP_BG2 = 8'h03;
`else
  localparam logic [7:0] EXP_FG2 = 8'hFF;
  localparam logic [7:0] EXP_BG2 = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic [9:0] x_in, y_in;
  logic       vidon_in, hsync_in, vsync_in;
  logic       cfg_we, cfg_sel;
  logic [7:0] cfg_data;

  logic [15:0] addr1, addr3;
  logic [7:0]  dout1, dout3;
  logic [2:0]  r1, g1, r3, g3;
  logic [1:0]  b1, b3;
  logic        hs1, vs1, tk1, hs3, vs3, tk3;

  int n_checks = 0;
  int n_errors = 0;
  bit running  = 1'b1;

  always #5 clk = ~clk;

  vga_scanout #(.RD_LAT(1), .FG_RESET(FG_RST), .BG_RESET(BG_RST)) u_dut1 (
    .clk(clk), .resetn(resetn), .x_in(x_in), .y_in(y_in), .vidon_in(vidon_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .vram_addrb(addr1), .vram_doutb(dout1),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .red(r1), .green(g1), .blue(b1), .hsync(hs1), .vsync(vs1), .frame_tick(tk1));

  vga_scanout #(.RD_LAT(3), .FG_RESET(FG_RST), .BG_RESET(BG_RST)) u_dut3 (
    .clk(clk), .resetn(resetn), .x_in(x_in), .y_in(y_in), .vidon_in(vidon_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .vram_addrb(addr3), .vram_doutb(dout3),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .red(r3), .green(g3), .blue(b3), .hsync(hs3), .vsync(vs3), .frame_tick(tk3));

  // VRAM contents: one marked byte for the directed sweep, a hash elsewhere.
  function automatic logic [7:0] vram_byte(input logic [15:0] a);
    if (a == 16'd22520) return 8'h86;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // VRAM port-B models with 1 and 3 cycles of read latency.
  logic [7:0] rd1;
  logic [7:0] rd3 [3];
  always @(posedge clk) begin
    rd1    <= vram_byte(addr1);
    rd3[0] <= vram_byte(addr3);
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign dout1 = rd1;
  assign dout3 = rd3[2];

  // Input history per clock edge, plus the palette in force before each edge.
  int         edge_n = 0;
  int         h_x [MAXE];
  int         h_y [MAXE];
  bit         h_vid [MAXE];
  bit         h_hs [MAXE];
  bit         h_vs [MAXE];
  bit         h_rst [MAXE];
  logic [7:0] fg_at [MAXE];
  logic [7:0] bg_at [MAXE];
  logic [7:0] cur_fg = FG_RST;
  logic [7:0] cur_bg = BG_RST;

  always @(posedge clk) begin
    if (edge_n + 1 < MAXE) begin
      h_x[edge_n+1]   <= int'(x_in);
      h_y[edge_n+1]   <= int'(y_in);
      h_vid[edge_n+1] <= vidon_in;
      h_hs[edge_n+1]  <= hsync_in;
      h_vs[edge_n+1]  <= vsync_in;
      h_rst[edge_n+1] <= !resetn;
      fg_at[edge_n+1] <= cur_fg;
      bg_at[edge_n+1] <= cur_bg;
    end
    if (!resetn) begin
      cur_fg <= FG_RST;
      cur_bg <= BG_RST;
    end
`ifdef SCANOUT_PALETTE_EN
    else if (cfg_we) begin
      if (cfg_sel) cur_bg <= cfg_data;
      else         cur_fg <= cfg_data;
    end
`endif
    edge_n <= edge_n + 1;
  end

  function automatic logic [15:0] model_addr(input int x, input int y);
    int a;
    a = y * 80 + x / 8;
    return a[15:0];
  endfunction

  // True when any pipeline edge feeding output edge n was a reset edge.
  function automatic bit rst_in_window(input int n, input int lat);
    for (int j = n - lat + 1; j <= n; j++)
      if (j < 1 || h_rst[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] exp_rgb(input int n, input int lat);
    int         k;
    logic [7:0] b;
    if (rst_in_window(n, lat)) return 8'h00;
    k = n - lat + 1;
    if (!h_vid[k]) return 8'h00;
    b = vram_byte(model_addr(h_x[k], h_y[k]));
    return b[h_x[k] % 8] ? fg_at[n] : bg_at[n];
  endfunction

  function automatic bit exp_hs(input int n, input int lat);
    if (rst_in_window(n, lat)) return 1'b1;
    return h_hs[n - lat + 1];
  endfunction

  function automatic bit exp_vs(input int n, input int lat);
    if (rst_in_window(n, lat)) return 1'b1;
    return h_vs[n - lat + 1];
  endfunction

  function automatic bit exp_tick(input int n, input int lat);
    if (h_rst[n]) return 1'b0;
    return exp_vs(n - 2, lat) && !exp_vs(n - 1, lat);
  endfunction

  function automatic logic [15:0] exp_addr(input int n);
    if (h_rst[n] || !h_vid[n]) return 16'd0;
    return model_addr(h_x[n], h_y[n]);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, half a cycle after each edge.
  always @(negedge clk) begin
    if (running && edge_n >= 1) begin
      chk("addr1", addr1, exp_addr(edge_n));
      chk("addr3", addr3, exp_addr(edge_n));
      chk("rgb1", {8'h00, r1, g1, b1}, {8'h00, exp_rgb(edge_n, L1)});
      chk("rgb3", {8'h00, r3, g3, b3}, {8'h00, exp_rgb(edge_n, L3)});
      chk("hsync1", {15'd0, hs1}, {15'd0, exp_hs(edge_n, L1)});
      chk("hsync3", {15'd0, hs3}, {15'd0, exp_hs(edge_n, L3)});
      chk("vsync1", {15'd0, vs1}, {15'd0, exp_vs(edge_n, L1)});
      chk("vsync3", {15'd0, vs3}, {15'd0, exp_vs(edge_n, L3)});
      chk("tick1", {15'd0, tk1}, {15'd0, exp_tick(edge_n, L1)});
      chk("tick3", {15'd0, tk3}, {15'd0, exp_tick(edge_n, L3)});
    end
  end

  task automatic drive(input int x, input int y, input bit vid, input bit hs, input bit vs);
    x_in     = x[9:0];
    y_in     = y[9:0];
    vidon_in = vid;
    hsync_in = hs;
    vsync_in = vs;
    @(negedge clk);
  endtask

  task automatic pal_write(input bit sel, input logic [7:0] data, input int x, input int y);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_data = data;
    drive(x, y, 1'b1, 1'b1, 1'b1);
    cfg_we   = 1'b0;
  endtask

  // Sweep x=320..327 on row 281 (byte 0x86) and check both latencies' sequence.
  task automatic sweep_check(input string tag, input logic [7:0] fgc, input logic [7:0] bgc);
    logic [7:0] cap1 [16];
    logic [7:0] cap3 [16];
    logic [7:0] pat;
    pat = 8'h86;
    for (int j = 0; j < 16; j++) begin
      if (j < 8) drive(320 + j, 281, 1'b1, 1'b1, 1'b1);
      else       drive(0, 0, 1'b0, 1'b1, 1'b1);
      cap1[j] = {r1, g1, b1};
      cap3[j] = {r3, g3, b3};
    end
    chk({tag, "_pre1"}, {8'h00, cap1[L1-2]}, 16'h0000);
    chk({tag, "_pre3"}, {8'h00, cap3[L3-2]}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_seq1"}, {8'h00, cap1[L1-1+i]}, {8'h00, pat[i] ? fgc : bgc});
      chk({tag, "_seq3"}, {8'h00, cap3[L3-1+i]}, {8'h00, pat[i] ? fgc : bgc});
    end
    chk({tag, "_blank1"}, {8'h00, cap1[L1-1+8]}, 16'h0000);
    chk({tag, "_blank3"}, {8'h00, cap3[L3-1+8]}, 16'h0000);
  endtask

  initial begin
    int first1, first3, cnt1, cnt3, pos1, pos3;
    resetn   = 1'b0;
    cfg_we   = 1'b0;
    cfg_sel  = 1'b0;
    cfg_data = 8'h00;

    // Reset held 3 cycles with vidon_in high.
    for (int i = 0; i < 3; i++) begin
      drive(321, 281, 1'b1, 1'b1, 1'b1);
      chk("rst_rgb", {8'h00, r1, g1, b1}, 16'h0000);
      chk("rst_addr", addr1, 16'd0);
      chk("rst_sync", {14'd0, hs1, vs1}, 16'h0003);
      chk("rst_tick", {15'd0, tk1}, 16'd0);
    end

    // Release: address one cycle later, first pixel no earlier than L.
    resetn = 1'b1;
    first1 = -1;
    first3 = -1;
    for (int j = 0; j < 6; j++) begin
      drive(321, 281, 1'b1, 1'b1, 1'b1);
      if (j == 0) chk("addr_22520", addr1, 16'd22520);
      if (first1 < 0 && {r1, g1, b1} != 8'h00) first1 = j;
      if (first3 < 0 && {r3, g3, b3} != 8'h00) first3 = j;
    end
    chk("first_pix1", first1[15:0], 16'(L1 - 1));
    chk("first_pix3", first3[15:0], 16'(L3 - 1));

    drive(325, 281, 1'b0, 1'b1, 1'b1);
    chk("addr_blank", addr1, 16'd0);
    for (int j = 0; j < 5; j++) drive(0, 0, 1'b0, 1'b1, 1'b1);

    sweep_check("sweep", FG_RST, BG_RST);

    drive(1023, 1023, 1'b1, 1'b1, 1'b1);
    chk("addr_wrap", addr1, 16'd16431);

    // 96-cycle hsync_in low pulse.
    first1 = -1; first3 = -1; cnt1 = 0; cnt3 = 0;
    for (int j = 0; j < 110; j++) begin
      drive(0, 0, 1'b0, (j >= 96), 1'b1);
      if (!hs1) begin cnt1++; if (first1 < 0) first1 = j; end
      if (!hs3) begin cnt3++; if (first3 < 0) first3 = j; end
    end
    chk("hs_start1", first1[15:0], 16'(L1 - 1));
    chk("hs_start3", first3[15:0], 16'(L3 - 1));
    chk("hs_len1", cnt1[15:0], 16'd96);
    chk("hs_len3", cnt3[15:0], 16'd96);

    // vsync_in falls and stays low: exactly one tick, L+1 cycles after the edge.
    cnt1 = 0; cnt3 = 0; pos1 = -1; pos3 = -1;
    for (int j = 0; j < 30; j++) begin
      drive(0, 0, 1'b0, 1'b1, 1'b0);
      if (tk1) begin cnt1++; pos1 = j; end
      if (tk3) begin cnt3++; pos3 = j; end
    end
    chk("tick_cnt1", cnt1[15:0], 16'd1);
    chk("tick_cnt3", cnt3[15:0], 16'd1);
    chk("tick_pos1", pos1[15:0], 16'(L1));
    chk("tick_pos3", pos3[15:0], 16'(L3));
    for (int j = 0; j < 4; j++) drive(0, 0, 1'b0, 1'b1, 1'b1);

    // Palette writes in the middle of an active line.
    for (int x = 0; x < 96; x++) begin
      if (x == 30)      pal_write(1'b0, 8'hE0, 300 + x, 281);
      else if (x == 60) pal_write(1'b1, 8'h03, 300 + x, 281);
      else              drive(300 + x, 281, 1'b1, 1'b1, 1'b1);
    end
    for (int j = 0; j < 5; j++) drive(0, 0, 1'b0, 1'b1, 1'b1);
    sweep_check("pal", EXP_FG2, EXP_BG2);

    // Reset mid-frame during active video.
    for (int x = 0; x < 8; x++) drive(320 + x, 281, 1'b1, 1'b1, 1'b1);
    resetn = 1'b0;
    drive(321, 281, 1'b1, 1'b0, 1'b0);
    chk("midrst_rgb", {8'h00, r1, g1, b1}, 16'h0000);
    drive(321, 281, 1'b1, 1'b0, 1'b0);
    resetn = 1'b1;
    for (int x = 0; x < 16; x++) drive(320 + (x % 8), 281, 1'b1, 1'b1, 1'b1);
    for (int j = 0; j < 8; j++) drive(0, 0, 1'b0, 1'b1, 1'b1);

    running = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
